// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with valid/ready handshake and an RV32M sequencer for an iterative MD unit.
// Optional: define ALU_CTRL_ILLEGAL_TRAP_EN to register and expose the illegal-decode flag.
module alu_control_seq #(
    parameter int OP_W       = 4,
    parameter int MD_LATENCY = 32,
    parameter int M_EXT      = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [2:0]      ALUop_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] alu_op,
    output logic [2:0]      md_func,
    output logic            md_start,
    output logic            busy,
    output logic            illegal
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OUT     = 2'd1;
    localparam logic [1:0] S_MD_BUSY = 2'd2;
    localparam logic [1:0] S_MD_DONE = 2'd3;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_MD    = 4'd11;

    localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] base_code;
    logic [3:0] dec_code;
    logic       dec_md;
    logic       dec_ill;
    logic       accept;
    logic       unused_instr_bits;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [OP_W-1:0]  alu_op_q,    alu_op_d;
    logic [2:0]       md_func_q,   md_func_d;
    logic             md_start_q,  md_start_d;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic             illegal_q,   illegal_d;
`endif

    assign funct3            = instruction[14:12];
    assign funct7            = instruction[31:25];
    assign unused_instr_bits = ^{instruction[24:15], instruction[11:0]};

    always_comb begin
        case (funct3)
            3'b000:  base_code = OP_ADD;
            3'b001:  base_code = OP_SLL;
            3'b010:  base_code = OP_SLT;
            3'b011:  base_code = OP_SLTU;
            3'b100:  base_code = OP_XOR;
            3'b101:  base_code = OP_SRL;
            3'b110:  base_code = OP_OR;
            default: base_code = OP_AND;
        endcase
    end

    // Illegal branches leave dec_code at ADD, which is the required fallback.
    always_comb begin
        dec_code = OP_ADD;
        dec_md   = 1'b0;
        dec_ill  = 1'b0;
        case (ALUop_in)
            3'b000: begin
                case (funct7)
                    7'b0000000: dec_code = base_code;
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec_code = OP_SUB;
                        else if (funct3 == 3'b101) dec_code = OP_SRA;
                        else                       dec_ill  = 1'b1;
                    end
                    7'b0000001: begin
                        if (M_EXT != 0) begin
                            dec_md   = 1'b1;
                            dec_code = OP_MD;
                        end else begin
                            dec_ill = 1'b1;
                        end
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            3'b001: begin
                case (funct3)
                    3'b000, 3'b001: dec_code = OP_SUB;
                    3'b100, 3'b101: dec_code = OP_SLT;
                    3'b110, 3'b111: dec_code = OP_SLTU;
                    default:        dec_ill  = 1'b1;
                endcase
            end
            3'b010: dec_code = OP_ADD;
            3'b011: dec_code = OP_PASSB;
            3'b100: begin
                if (funct3 == 3'b101) dec_code = instruction[30] ? OP_SRA : OP_SRL;
                else                  dec_code = base_code;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // OUT re-accepts while its result is being consumed, giving one op per cycle.
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        alu_op_d    = alu_op_q;
        md_func_d   = md_func_q;
        md_start_d  = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        case (state_q)
            S_IDLE, S_OUT: begin
                if ((state_q == S_OUT) && out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    alu_op_d = OP_W'(dec_code);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                    illegal_d = dec_ill;
`endif
                    if (dec_md) begin
                        state_d     = S_MD_BUSY;
                        md_start_d  = 1'b1;
                        cnt_d       = CNT_LOAD;
                        md_func_d   = funct3;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d     = S_OUT;
                        md_func_d   = 3'b000;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d     = S_MD_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            alu_op_q    <= '0;
            md_func_q   <= '0;
            md_start_q  <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            alu_op_q    <= alu_op_d;
            md_func_q   <= md_func_d;
            md_start_q  <= md_start_d;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign alu_op    = alu_op_q;
    assign md_func   = md_func_q;
    assign md_start  = md_start_q;
    assign busy      = (state_q == S_MD_BUSY) || (state_q == S_MD_DONE);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    assign illegal   = illegal_q;
`else
    assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed plus randomized bench for alu_control_seq against a table-driven reference decoder.
module tb_alu_control_seq;

    localparam int OP_W = 6;
    localparam int LAT  = 4;
    localparam int R0_TAB [8] = '{0, 5, 8, 9, 4, 6, 3, 2};

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [2:0]      ALUop_in;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] alu_op;
    logic [2:0]      md_func;
    logic            md_start;
    logic            busy;
    logic            illegal;

    int checks   = 0;
    int failures = 0;

    alu_control_seq #(.OP_W(OP_W), .MD_LATENCY(LAT), .M_EXT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .ALUop_in(ALUop_in), .out_valid(out_valid),
        .out_ready(out_ready), .alu_op(alu_op), .md_func(md_func),
        .md_start(md_start), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the operation tables.
    function automatic void model(input logic [2:0] aop, input logic [31:0] ins,
                                  output int op, output bit md, output bit ill);
        int f3;
        int f7;
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        op  = 0;
        md  = 0;
        ill = 0;
        case (aop)
            3'd0: begin
                if (f7 == 0)                  op = R0_TAB[f3];
                else if (f7 == 32 && f3 == 0) op = 1;
                else if (f7 == 32 && f3 == 5) op = 7;
                else if (f7 == 1) begin md = 1; op = 11; end
                else                          ill = 1;
            end
            3'd1: begin
                if (f3 < 2)      op = 1;
                else if (f3 < 4) ill = 1;
                else if (f3 < 6) op = 8;
                else             op = 9;
            end
            3'd2: op = 0;
            3'd3: op = 10;
            3'd4: op = (f3 == 5) ? (ins[30] ? 7 : 6) : R0_TAB[f3];
            default: ill = 1;
        endcase
        if (ill) op = 0;
    endfunction

    task automatic run_op(input logic [2:0] aop, input logic [31:0] ins, input int hold);
        int eop;
        bit emd;
        bit eill;
        logic [2:0] ef3;
        model(aop, ins, eop, emd, eill);
`ifndef ALU_CTRL_ILLEGAL_TRAP_EN
        eill = 0;
`endif
        ef3 = ins[14:12];
        out_ready = 1'b1; ALUop_in = aop; instruction = ins; in_valid = 1'b1;
        #1;
        check("in_ready_pre", in_ready, 1);
        @(posedge clk); #1;
        out_ready   = (hold == 0);
        in_valid    = 1'($urandom_range(0, 1));
        instruction = $urandom;
        ALUop_in    = 3'($urandom_range(0, 7));
        #1;
        if (!emd) begin
            check("out_valid", out_valid, 1);
            check("alu_op", alu_op, eop);
            check("illegal", illegal, eill);
            check("md_func_zero", md_func, 0);
            check("md_start_low", md_start, 0);
            check("busy_low", busy, 0);
            check("in_ready_out", in_ready, hold == 0);
            repeat (hold) begin
                @(posedge clk); #2;
                check("hold_valid", out_valid, 1);
                check("hold_op", alu_op, eop);
                check("hold_illegal", illegal, eill);
                check("hold_in_ready", in_ready, 0);
            end
        end else begin
            check("md_start_pulse", md_start, 1);
            check("md_busy", busy, 1);
            check("md_no_valid", out_valid, 0);
            check("md_func", md_func, ef3);
            check("md_in_ready", in_ready, 0);
            for (int k = 1; k < LAT; k++) begin
                @(posedge clk); #2;
                check("md_start_once", md_start, 0);
                check("md_wait_valid", out_valid, 0);
                check("md_wait_busy", busy, 1);
            end
            @(posedge clk); #2;
            check("md_done_valid", out_valid, 1);
            check("md_done_op", alu_op, 11);
            check("md_done_func", md_func, ef3);
            check("md_done_busy", busy, 1);
            check("md_done_start", md_start, 0);
            check("md_done_illegal", illegal, 0);
            repeat (hold) begin
                @(posedge clk); #2;
                check("md_hold_valid", out_valid, 1);
                check("md_hold_op", alu_op, 11);
                check("md_hold_in_ready", in_ready, 0);
                check("md_hold_busy", busy, 1);
            end
            out_ready = 1'b1; in_valid = 1'b0;
            @(posedge clk); #2;
            check("md_release_busy", busy, 0);
            check("md_release_valid", out_valid, 0);
            check("md_release_in_ready", in_ready, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        bit seen;
        logic [31:0] ins;
        logic [2:0]  aop;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instruction = '0; ALUop_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_md_start", md_start, 0);
        check("rst_busy", busy, 0);
        check("rst_illegal", illegal, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        run_op(3'b000, 32'h0000_0000, 0);
        run_op(3'b000, 32'h4000_0000, 0);
        run_op(3'b000, 32'h4000_5000, 0);
        run_op(3'b000, 32'h0000_7000, 0);

        run_op(3'b001, 32'h0000_0000, 0);
        run_op(3'b001, 32'h0000_6000, 1);
        run_op(3'b001, 32'h0000_7000, 0);
        run_op(3'b010, 32'h0000_2000, 0);
        run_op(3'b011, 32'h1234_5678, 2);
        run_op(3'b100, 32'h4000_5000, 0);
        run_op(3'b100, 32'h0200_5000, 0);

        run_op(3'b000, 32'h0200_4000, 3);

        run_op(3'b000, 32'h4000_1000, 0);
        run_op(3'b110, 32'h0000_0000, 0);
        run_op(3'b001, 32'h0000_2000, 1);

        // Reset in the middle of an MD op must abort it completely.
        ALUop_in = 3'b000; instruction = 32'h0200_4000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_md_start", md_start, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_alu_op", alu_op, 0);
        check("abort_md_func", md_func, 0);
        check("abort_md_start_low", md_start, 0);
        check("abort_busy", busy, 0);
        check("abort_illegal", illegal, 0);
        check("abort_in_ready", in_ready, 1);
        seen = 0;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (out_valid || md_start) seen = 1;
        end
        check("abort_no_activity", seen, 0);
        run_op(3'b000, 32'h0000_0000, 0);

        for (int i = 0; i < 60; i++) begin
            ins = $urandom;
            aop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'b0000000;
                1: ins[31:25] = 7'b0100000;
                2: ins[31:25] = 7'b0000001;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) aop = 3'($urandom_range(0, 1)) << 2;
            run_op(aop, ins, $urandom_range(0, 2));
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
